// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: requester, generator and status signals of the draw scheduler
interface draw_scheduler_if #(
  parameter int LW = 3,
  parameter int CW = 16
);
  logic          req0_valid;
  logic [7:0]    req0_x;
  logic [7:0]    req0_y;
  logic          req0_ready;
  logic          req1_valid;
  logic [7:0]    req1_x;
  logic [7:0]    req1_y;
  logic          req1_ready;
  logic [2:0]    brush_cfg;
  logic [1:0]    sym_cfg;
  logic          flush;
  logic          gen_trigger;
  logic [7:0]    gen_x;
  logic [7:0]    gen_y;
  logic [2:0]    gen_brush;
  logic [1:0]    gen_sym;
  logic          gen_busy;
  logic          gen_valid;
  logic [LW-1:0] fifo_level;
  logic [CW-1:0] pix_total;
  logic          err_count;
  logic          err_timeout;
  modport slave (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    input  brush_cfg, sym_cfg, flush, gen_busy, gen_valid,
    output req0_ready, req1_ready, gen_trigger, gen_x, gen_y, gen_brush, gen_sym,
    output fifo_level, pix_total, err_count, err_timeout
  );
  modport master (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    output brush_cfg, sym_cfg, flush, gen_busy, gen_valid,
    input  req0_ready, req1_ready, gen_trigger, gen_x, gen_y, gen_brush, gen_sym,
    input  fifo_level, pix_total, err_count, err_timeout
  );
endinterface

// File: rtl/draw_scheduler.sv
// draw_scheduler: round-robin command intake, FIFO, one-at-a-time launch and pixel-count checking
module draw_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int DEDUP_EN   = 1
) (
  input logic clk,
  input logic rst_n,
  draw_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;
  state_t state, state_nx;
  logic [20:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [20:0] cmd, hist, gen_cmd;
  logic rr, hist_v, grant0, grant1, full, empty, accept, dup, push, pop;
  logic tmo_hit, run_done, trigger, err_cnt, err_tmo;
  logic [1:0] tmo;
  logic [8:0] pix_cmd, expected;
  logic [3:0] bsz;
  logic [6:0] area;
  logic [CNT_W-1:0] total;
  assign full = level == LW'(FIFO_DEPTH);
  assign empty = level == '0;
  assign grant0 = bus.req0_valid & (~bus.req1_valid | ~rr);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | rr);
  assign bus.req0_ready = grant0 & ~full & ~bus.flush;
  assign bus.req1_ready = grant1 & ~full & ~bus.flush;
  assign accept = bus.req0_ready | bus.req1_ready;
  assign cmd = grant1 ? {bus.req1_x, bus.req1_y, bus.brush_cfg, bus.sym_cfg}
                      : {bus.req0_x, bus.req0_y, bus.brush_cfg, bus.sym_cfg};
  assign dup = (DEDUP_EN != 0) && hist_v && (cmd == hist);
  assign push = accept & ~dup;
  // (brush+1)^2 scaled by 1/2/2/4 mirror copies
  assign bsz = {1'b0, gen_cmd[4:2]} + 4'd1;
  assign area = 7'(bsz * bsz);
  assign expected = gen_cmd[1:0] == 2'd3 ? {area, 2'b00} :
                    gen_cmd[1:0] == 2'd0 ? {2'b00, area} : {1'b0, area, 1'b0};
  assign bus.gen_x = gen_cmd[20:13];
  assign bus.gen_y = gen_cmd[12:5];
  assign bus.gen_brush = gen_cmd[4:2];
  assign bus.gen_sym = gen_cmd[1:0];
  assign bus.gen_trigger = trigger;
  assign bus.fifo_level = level;
  assign bus.pix_total = total;
  assign bus.err_count = err_cnt;
  assign bus.err_timeout = err_tmo;
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // FSM next state: launch when idle with work, wait for busy, then wait for completion
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = (~empty & ~bus.gen_busy) ? LAUNCH : IDLE;
      LAUNCH:  state_nx = bus.gen_busy ? RUN : (tmo == 2'd3) ? IDLE : LAUNCH;
      RUN:     state_nx = bus.gen_busy ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // FSM outputs: pop/launch, launch timeout and end-of-command events
  always_comb begin
    pop = (state == IDLE) & ~empty & ~bus.gen_busy;
    tmo_hit = (state == LAUNCH) & ~bus.gen_busy & (tmo == 2'd3);
    run_done = (state == RUN) & ~bus.gen_busy;
  end
  // FIFO storage; entries need no reset since level guards reads
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= cmd;
  // FIFO pointers, level, round-robin pointer and dedup history
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      rr <= 1'b0;
      hist <= '0;
      hist_v <= 1'b0;
    end else begin
      wr_ptr <= bus.flush ? '0 : wr_ptr + AW'(push);
      rd_ptr <= bus.flush ? '0 : rd_ptr + AW'(pop);
      level <= bus.flush ? '0 : level + LW'(push) - LW'(pop);
      rr <= accept ? grant0 : rr;
      hist <= push ? cmd : hist;
      hist_v <= ~bus.flush & (hist_v | push);
    end
  // launch registers, counters and sticky error flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gen_cmd <= '0;
      trigger <= 1'b0;
      tmo <= '0;
      pix_cmd <= '0;
      total <= '0;
      err_cnt <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      gen_cmd <= pop ? mem[rd_ptr] : gen_cmd;
      trigger <= pop;
      tmo <= (state == LAUNCH) ? tmo + 2'd1 : 2'd0;
      pix_cmd <= pop ? 9'd0 : (bus.gen_valid & (state != IDLE)) ? pix_cmd + 9'd1 : pix_cmd;
      total <= (bus.gen_valid & ~&total) ? total + CNT_W'(1) : total;
      err_cnt <= err_cnt | (run_done & (pix_cmd != expected));
      err_tmo <= err_tmo | tmo_hit;
    end
endmodule
